// File: rtl/cmos_probe_pkg.sv
// Shared types and constants for the CMOS gate prober: FSM states, vector order
// and reference truth tables (bit index = {a,b}).
package cmos_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Vectors are applied as a binary count {a,b} from VEC_FIRST to VEC_LAST.
  localparam logic [1:0] VEC_FIRST = 2'b00;
  localparam logic [1:0] VEC_LAST  = 2'b11;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/cmos_probe_cmp.sv
// Sample-vs-expected compare. The X/Z test only has meaning in a 4-state
// simulator; in hardware the node is always 0 or 1 and the compare is 2-state.
module cmos_probe_cmp (
  input  logic sample,
  input  logic expected,
  output logic mismatch,
  output logic is_xz
);

  assign is_xz    = (sample !== 1'b0) && (sample !== 1'b1);
  assign mismatch = (sample !== expected);

endmodule

// File: rtl/cmos_gate_prober.sv
// Drives the four {a,b} vectors into a 2-input CMOS cell, waits SETTLE cycles,
// samples f and accumulates mismatch statistics against a captured truth table.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start; results of the last run held
// ST_SETTLE | vector driven, settle counter running down to 1
// ST_SAMPLE | probe_f compared against tt[idx]; next vector or finish
// ST_DONE   | one-cycle done pulse, then back to idle
module cmos_gate_prober
  import cmos_probe_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       truth_table,
  output logic             probe_a,
  output logic             probe_b,
  input  logic             probe_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic             xz_seen
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("cmos_gate_prober: SETTLE must be at least 1");
  end
  if (PASSES < 1) begin : g_bad_passes
    $error("cmos_gate_prober: PASSES must be at least 1");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_tt;
  logic [1:0]       r_idx;
  logic [PW-1:0]    r_pass_cnt;
  logic [SW-1:0]    r_cnt;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_fail_vec;
  logic             r_xz;

  logic             w_accept;
  logic             w_last_vec;
  logic             w_last_pass;
  logic             w_cnt_term;
  logic             w_expected;
  logic             w_mismatch;
  logic             w_is_xz;
  logic [ERR_W-1:0] w_err_nxt;
  logic [1:0]       w_idx_inc;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_last_vec  = (r_idx == VEC_LAST);
  assign w_last_pass = (r_pass_cnt == PW'(PASSES - 1));
  assign w_cnt_term  = (r_cnt == SW'(1));
  assign w_expected  = r_tt[r_idx];
  assign w_idx_inc   = r_idx + 2'd1;
  // Error count sticks at all-ones rather than wrapping.
  assign w_err_nxt   = (w_mismatch && !(&r_err)) ? r_err + ERR_W'(1) : r_err;

  cmos_probe_cmp u_cmp (
    .sample   (probe_f),
    .expected (w_expected),
    .mismatch (w_mismatch),
    .is_xz    (w_is_xz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_cnt_term) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = (w_last_vec && w_last_pass) ? ST_DONE : ST_SETTLE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tt       <= 4'd0;
      r_idx      <= VEC_FIRST;
      r_pass_cnt <= '0;
      r_cnt      <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_fail_vec <= 4'd0;
      r_xz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tt       <= truth_table;
            r_idx      <= VEC_FIRST;
            r_pass_cnt <= '0;
            r_cnt      <= SW'(SETTLE);
            {r_a, r_b} <= VEC_FIRST;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_fail_vec <= 4'd0;
            r_xz       <= 1'b0;
          end
        end
        ST_SETTLE: r_cnt <= r_cnt - SW'(1);
        ST_SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_mismatch) r_fail_vec[r_idx] <= 1'b1;
          if (w_is_xz)    r_xz <= 1'b1;
          if (!w_last_vec) begin
            r_idx      <= w_idx_inc;
            {r_a, r_b} <= w_idx_inc;
            r_cnt      <= SW'(SETTLE);
          end else if (!w_last_pass) begin
            r_idx      <= VEC_FIRST;
            r_pass_cnt <= r_pass_cnt + PW'(1);
            {r_a, r_b} <= VEC_FIRST;
            r_cnt      <= SW'(SETTLE);
          end else begin
            // Probes stay on the last vector; pass includes this final sample.
            r_pass <= (w_err_nxt == '0);
            r_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign probe_a   = r_a;
  assign probe_b   = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail_vec;
  assign xz_seen   = r_xz;

endmodule
